// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared width codes, entry type and byte-lane helpers for the store buffer
package sb_pkg;

    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic [31:0] pc;
        logic [3:0]  mask;
        logic [31:0] lane;
    } sb_entry_t;

    function automatic logic [3:0] byte_mask(input logic [1:0] addr, input logic [1:0] width);
        logic [3:0] m;
        case (width)
            WORD:    m = 4'b1111;
            HALF:    m = addr[1] ? 4'b1100 : 4'b0011;
            BYTE:    m = 4'b0001 << addr;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] mask_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Replicated value is trimmed to the masked lanes so unused lanes hold zero.
    function automatic logic [31:0] lane_data(input logic [31:0] data, input logic [1:0] addr,
                                              input logic [1:0] width);
        logic [31:0] rep;
        case (width)
            WORD:    rep = data;
            HALF:    rep = {2{data[15:0]}};
            BYTE:    rep = {4{data[7:0]}};
            default: rep = 32'h0;
        endcase
        return rep & mask_bits(byte_mask(addr, width));
    endfunction

endpackage

// File: rtl/sb_lookup.sv
// rtl/sb_lookup.sv - combinational youngest-wins byte merge of queued stores for a load lookup
module sb_lookup
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             ent_valid [DEPTH],
    input  logic [29:0]      ent_tag   [DEPTH],
    input  logic [3:0]       ent_mask  [DEPTH],
    input  logic [31:0]      ent_lane  [DEPTH],
    input  logic [PTR_W-1:0] head,
    input  logic             req,
    input  logic [31:0]      addr,
    input  logic [1:0]       width,
    output logic             hit,
    output logic             stall,
    output logic [31:0]      data
);

    logic [3:0]       req_mask;
    logic [3:0]       covered;
    logic [3:0]       covered_req;
    logic [31:0]      merged;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so later matches overwrite earlier ones per lane.
    always_comb begin
        req_mask    = byte_mask(addr[1:0], width);
        covered     = 4'b0;
        merged      = 32'h0;
        idx         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (ent_valid[idx] && ent_tag[idx] == addr[31:2]) begin
                for (int l = 0; l < 4; l++) begin
                    if (ent_mask[idx][l]) begin
                        merged[8*l +: 8] = ent_lane[idx][8*l +: 8];
                        covered[l]       = 1'b1;
                    end
                end
            end
        end
        covered_req = covered & req_mask;
        hit   = req && (req_mask != 4'b0) && (covered_req == req_mask);
        stall = req && (covered_req != 4'b0) && (covered_req != req_mask);
        data  = hit ? (merged & mask_bits(req_mask)) : 32'h0;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO between MEM stage and data memory with load forwarding
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             StReq,
    input  logic [31:0]      StAddr,
    input  logic [31:0]      StData,
    input  logic [1:0]       StWidth,
    input  logic [31:0]      StPC,
    output logic             StReady,
    input  logic             LdReq,
    input  logic [31:0]      LdAddr,
    input  logic [1:0]       LdWidth,
    output logic             LdHit,
    output logic             LdStall,
    output logic [31:0]      LdData,
    input  logic             DmBusy,
    output logic             DmWe,
    output logic [31:0]      DmAddr,
    output logic [31:0]      DmWD,
    output logic [1:0]       DmWidth,
    output logic [31:0]      DmPC,
    output logic [CNT_W-1:0] Count
);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             enq;
    logic             deq;
    logic             nonempty;

    logic             ent_valid [DEPTH];
    logic [29:0]      ent_tag   [DEPTH];
    logic [3:0]       ent_mask  [DEPTH];
    logic [31:0]      ent_lane  [DEPTH];

    // No bypass when full: a slot must already be free before the edge.
    assign StReady  = count < CNT_W'(DEPTH);
    assign nonempty = count != '0;
    assign enq      = StReq && StReady && (StWidth != 2'b11);
    assign deq      = nonempty && !DmBusy;

    assign DmWe    = deq;
    assign DmAddr  = nonempty ? entries[head].addr  : 32'h0;
    assign DmWD    = nonempty ? entries[head].data  : 32'h0;
    assign DmWidth = nonempty ? entries[head].width : 2'b00;
    assign DmPC    = nonempty ? entries[head].pc    : 32'h0;
    assign Count   = count;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (deq) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (enq) begin
                entries[tail] <= '{valid: 1'b1,
                                   addr:  StAddr,
                                   data:  StData,
                                   width: StWidth,
                                   pc:    StPC,
                                   mask:  byte_mask(StAddr[1:0], StWidth),
                                   lane:  lane_data(StData, StAddr[1:0], StWidth)};
                tail          <= tail + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_tag[i]   = entries[i].addr[31:2];
            ent_mask[i]  = entries[i].mask;
            ent_lane[i]  = entries[i].lane;
        end
    end

    sb_lookup #(.DEPTH(DEPTH)) u_lookup (
        .ent_valid (ent_valid),
        .ent_tag   (ent_tag),
        .ent_mask  (ent_mask),
        .ent_lane  (ent_lane),
        .head      (head),
        .req       (LdReq),
        .addr      (LdAddr),
        .width     (LdWidth),
        .hit       (LdHit),
        .stall     (LdStall),
        .data      (LdData)
    );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized self-checking bench for store_buffer against a queue model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        StReq = 1'b0;
    logic [31:0] StAddr = '0;
    logic [31:0] StData = '0;
    logic [1:0]  StWidth = '0;
    logic [31:0] StPC = '0;
    logic        StReady;
    logic        LdReq = 1'b0;
    logic [31:0] LdAddr = '0;
    logic [1:0]  LdWidth = '0;
    logic        LdHit;
    logic        LdStall;
    logic [31:0] LdData;
    logic        DmBusy = 1'b0;
    logic        DmWe;
    logic [31:0] DmAddr;
    logic [31:0] DmWD;
    logic [1:0]  DmWidth;
    logic [31:0] DmPC;
    logic [2:0]  Count;

    int n_checks = 0;
    int n_fail   = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset),
        .StReq(StReq), .StAddr(StAddr), .StData(StData), .StWidth(StWidth), .StPC(StPC),
        .StReady(StReady),
        .LdReq(LdReq), .LdAddr(LdAddr), .LdWidth(LdWidth),
        .LdHit(LdHit), .LdStall(LdStall), .LdData(LdData),
        .DmBusy(DmBusy), .DmWe(DmWe), .DmAddr(DmAddr), .DmWD(DmWD),
        .DmWidth(DmWidth), .DmPC(DmPC), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of committed stores, oldest at the front.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [1:0]  width;
    } st_t;
    st_t q[$];

    function automatic int wsize(input logic [1:0] w);
        case (w)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a, input int sz);
        return a & ~(32'(sz) - 32'd1);
    endfunction

    task automatic model_lookup(output logic hit, output logic stall, output logic [31:0] data);
        int sz, got, b, sb, ssz;
        logic [31:0] acc;
        logic [31:0] ba;
        hit = 0; stall = 0; data = 0; acc = 0; got = 0;
        sz = wsize(LdWidth);
        if (!LdReq || sz == 0) return;
        for (int k = 0; k < sz; k++) begin
            ba = base_of(LdAddr, sz) + 32'(k);
            for (int j = q.size() - 1; j >= 0; j--) begin
                ssz = wsize(q[j].width);
                sb  = int'(ba - base_of(q[j].addr, ssz));
                if (ba >= base_of(q[j].addr, ssz) && sb < ssz) begin
                    b = int'(ba[1:0]);
                    acc[8*b +: 8] = q[j].data[8*sb +: 8];
                    got++;
                    break;
                end
            end
        end
        hit   = (got == sz);
        stall = (got > 0) && (got < sz);
        data  = hit ? acc : 32'h0;
    endtask

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            q.delete();
        end else begin
            automatic bit deq = (q.size() != 0) && !DmBusy;
            automatic bit enq = StReq && (q.size() < DEPTH) && (StWidth != 2'b11);
            if (deq) void'(q.pop_front());
            if (enq) q.push_back('{StAddr, StData, StPC, StWidth});
        end
    end

    always @(negedge Clk) begin
        logic e_hit, e_stall, e_we;
        logic [31:0] e_data;
        model_lookup(e_hit, e_stall, e_data);
        e_we = (q.size() != 0) && !DmBusy;
        check("count", 32'(Count), 32'(q.size()));
        check("st_ready", 32'(StReady), 32'(q.size() < DEPTH));
        check("dm_we", 32'(DmWe), 32'(e_we));
        if (e_we) begin
            check("dm_addr", DmAddr, q[0].addr);
            check("dm_wd", DmWD, q[0].data);
            check("dm_width", 32'(DmWidth), 32'(q[0].width));
            check("dm_pc", DmPC, q[0].pc);
        end
        check("ld_hit", 32'(LdHit), 32'(e_hit));
        check("ld_stall", 32'(LdStall), 32'(e_stall));
        if (e_hit) check("ld_data", LdData, e_data);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
        StReq = 1'b1; StAddr = a; StData = d; StWidth = w; StPC = 32'h1000 + a;
        tick();
        StReq = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_count", 32'(Count), 0);
        check("rst_ready", 32'(StReady), 1);
        check("rst_we", 32'(DmWe), 0);
        check("rst_hit", 32'(LdHit), 0);
        check("rst_stall", 32'(LdStall), 0);
        check("rst_ld_data", LdData, 0);
        check("rst_dm_addr", DmAddr, 0);
        tick();
        Reset = 1'b1;

        store(32'h10, 32'hDEADBEEF, 2'b00);
        @(negedge Clk);
        check("t1_we", 32'(DmWe), 1);
        check("t1_addr", DmAddr, 32'h10);
        check("t1_wd", DmWD, 32'hDEADBEEF);
        tick();
        check("t1_count", 32'(Count), 0);

        DmBusy = 1'b1;
        store(32'h21, 32'h000000AB, 2'b10);
        store(32'h22, 32'h00001234, 2'b01);
        LdReq = 1'b1; LdAddr = 32'h20; LdWidth = 2'b00;
        #1;
        check("t2_word_stall", 32'(LdStall), 1);
        check("t2_word_hit", 32'(LdHit), 0);
        LdAddr = 32'h22; LdWidth = 2'b01;
        #1;
        check("t2_half_hit", 32'(LdHit), 1);
        check("t2_half_data", LdData, 32'h12340000);
        LdReq = 1'b0;
        store(32'h30, 32'h11111111, 2'b00);
        store(32'h30, 32'h00000022, 2'b10);
        LdReq = 1'b1; LdAddr = 32'h30; LdWidth = 2'b00;
        #1;
        check("t3_hit", 32'(LdHit), 1);
        check("t3_data", LdData, 32'h11111122);
        LdReq = 1'b0;
        DmBusy = 1'b0;
        repeat (4) tick();

        DmBusy = 1'b1;
        for (int k = 0; k < 4; k++) store(32'h40 + 32'(4*k), 32'hA0 + 32'(k), 2'b00);
        check("t4_ready", 32'(StReady), 0);
        check("t4_count", 32'(Count), 4);
        store(32'h50, 32'hBAD, 2'b00);
        check("t4_dropped", 32'(Count), 4);
        DmBusy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            check("t4_drain_we", 32'(DmWe), 1);
            check("t4_drain_addr", DmAddr, 32'h40 + 32'(4*k));
        end
        @(negedge Clk);
        check("t4_empty_we", 32'(DmWe), 0);

        tick();
        DmBusy = 1'b1;
        for (int k = 0; k < 3; k++) store(32'h60 + 32'(k), 32'h55, 2'b10);
        DmBusy = 1'b0;
        #1;
        check("t5_pre_we", 32'(DmWe), 1);
        #1;
        Reset = 1'b0;
        #1;
        check("t5_count", 32'(Count), 0);
        check("t5_we", 32'(DmWe), 0);
        check("t5_ready", 32'(StReady), 1);
        tick();
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("t5_no_write", 32'(DmWe), 0);
        end

        for (int c = 0; c < 3000; c++) begin
            tick();
            StReq   = $urandom_range(0, 1);
            StAddr  = 32'h100 + 32'($urandom_range(0, 15));
            StData  = $urandom;
            StWidth = 2'($urandom_range(0, 3));
            StPC    = $urandom;
            LdReq   = $urandom_range(0, 1);
            LdAddr  = 32'h100 + 32'($urandom_range(0, 15));
            LdWidth = 2'($urandom_range(0, 3));
            DmBusy  = ((c / 200) % 2 == 1) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
        end
        tick();
        StReq = 1'b0; LdReq = 1'b0; DmBusy = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the MEM-stage pipeline register and the data memory. Accepts committed stores (word/half/byte) from the MEM stage, queues them in a small in-order FIFO, and drains them one per cycle to the data memory's write port whenever that port is not claimed by a load. Serves MEM-stage loads by byte-wise forwarding from queued stores, and requests a stall when a load only partly overlaps queued data.

## Interface
- DEPTH, 4: number of entries, power of two, ≥2
- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- StReq  in  1  store request from MEM stage, valid this cycle
- StAddr  in  32  store byte address
- StData  in  32  store data, value in low bits (WD[15:0] half, WD[7:0] byte)
- StWidth  in  2  00 word, 01 half, 10 byte; 11 illegal, ignored
- StPC  in  32  PC of the storing instruction, carried to memory for trace
- StReady  out  1  buffer can accept a store this cycle
- LdReq  in  1  MEM-stage load lookup valid
- LdAddr  in  32  load byte address
- LdWidth  in  2  same encoding as StWidth
- LdHit  out  1  all requested bytes supplied from buffer
- LdStall  out  1  some but not all requested bytes present in buffer
- LdData  out  32  forwarded word, bytes in memory lane positions, unextended
- DmBusy  in  1  memory port used by a load miss this cycle; drain suppressed
- DmWe  out  1  write strobe to data memory
- DmAddr  out  32  write address
- DmWD  out  32  write data, original StData
- DmWidth  out  2  write width
- DmPC  out  32  PC for the write trace
- Count  out  log2(DEPTH)+1  occupied entries

## Operation
- Entry fields: valid, Addr[31:0], Data[31:0], Width, PC, byte mask[3:0], lane data[31:0].
- Byte mask: word 1111; half Addr[1]=1 → 1100, else 0011; byte → one-hot of Addr[1:0]. Lane data: StData[15:0] or StData[7:0] replicated into the masked lanes; word unchanged.
- Enqueue: StReq && StReady && StWidth≠11 writes entry at tail, tail+1 mod DEPTH. StReq with StReady=0 is dropped; upstream must hold.
- StReady = Count < DEPTH; no same-cycle bypass when full, even if draining.
- Drain: DmWe = (Count≠0) && !DmBusy; DmAddr/DmWD/DmWidth/DmPC = head entry fields. On the edge with DmWe=1, head+1 mod DEPTH, entry invalidated.
- Simultaneous enqueue and drain: Count unchanged; both pointers advance.
- Lookup (combinational, registered entries only): compare Addr[31:2] of each valid entry with LdAddr[31:2]; per byte lane, the youngest matching entry wins. Request mask from LdAddr/LdWidth per the store rule. Covered = union of matched masks ∧ request mask.
- Covered = request mask → LdHit=1, LdData = merged lanes (uncovered lanes 0). Covered ≠ 0 but ≠ request → LdStall=1, LdHit=0. Covered = 0 → both 0; load goes to memory. LdReq=0 or LdWidth=11 → LdHit=LdStall=0.
- A store enqueued in the same cycle is not visible to that cycle's lookup.

## Timing
- Reset asserted (low): all entries invalid, head=tail=0, Count=0, DmWe=0, StReady=1, LdHit=0, LdStall=0, LdData=0, DmAddr/DmWD/DmPC=0, DmWidth=00. Immediate, mid-drain included; queued stores are lost.
- Enqueue-to-memory latency: minimum 1 cycle (enqueue on edge n, DmWe high during cycle n+1).
- Drain throughput 1 store/cycle while DmBusy=0; DmBusy held high stalls drain indefinitely, contents unchanged.
- Lookup outputs valid in the same cycle as LdReq/LdAddr.
- Pointers wrap modulo DEPTH; full = Count==DEPTH, empty = Count==0.

## Structure
- Package sb_pkg: width codes WORD=2'b00, HALF=2'b01, BYTE=2'b10; functions byte_mask(addr[1:0], width) and lane_data(data, addr[1:0], width), shared by enqueue and lookup.
- One sub-module, sb_lookup: combinational youngest-wins byte merge across entries, producing LdHit, LdStall, LdData.

## Test plan
- Reset low, then word store 0x0000_0010 ← 0xDEADBEEF → next cycle DmWe=1, DmAddr=0x10, DmWD=0xDEADBEEF, Count returns to 0 after the edge.
- DmBusy=1; byte stores to 0x21 ← 0xAB, then half to 0x22 ← 0x1234; word load 0x20 → LdStall=1; half load 0x22 → LdHit=1, LdData=0x1234_0000.
- DmBusy=1; word 0x30 ← 0x11111111, then byte 0x30 ← 0x22; word load 0x30 → LdHit=1, LdData=0x11111122.
- DmBusy=1; fill 4 stores → StReady=0, Count=4; 5th StReq dropped; release DmBusy → 4 writes in order on 4 consecutive cycles.
- Enqueue and drain in same cycle at Count=2 → Count stays 2; pointer wrap after 6 mixed stores, drain order matches enqueue order.
- Reset pulsed low while Count=3 → Count=0, DmWe=0 immediately; no writes after release.
